// File: rtl/prism_sit_readback.sv
// prism_sit_readback
// Streams one WIDTH-bit SIT entry back over the 32-bit debug bus, one word per
// DATA read, from a shadow copy taken once the loader is idle.
// Build option: define PRISM_SIT_RB_AUTOINC_EN to step to the next entry after the
// last word, so back-to-back DATA reads dump the whole SIT.
module prism_sit_readback #(
    parameter  int unsigned WIDTH  = 80,
    parameter  int unsigned DEPTH  = 2,
    localparam int unsigned A_BITS = (DEPTH <= 2) ? 1 : $clog2(DEPTH),
    localparam int unsigned WORDS  = (WIDTH + 31) / 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [5:0]               debug_addr,
    input  logic                     debug_wr,
    input  logic                     debug_rd,
    input  logic [31:0]              debug_wdata,
    output logic [31:0]              debug_rdata,
    input  logic [WIDTH*DEPTH-1:0]   config_bus,
    input  logic                     config_busy
);

    localparam int unsigned PAD_W = WORDS * 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_READY   = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [A_BITS-1:0]    r_entry;
    logic [7:0]           r_word_idx;
    logic                 r_err;
    logic                 r_underrun;
    logic [WIDTH-1:0]     r_shadow;

    logic                 w_ctrl_sel;
    logic                 w_data_sel;
    logic                 w_ctrl_wr;
    logic                 w_start;
    logic                 w_clr;
    logic                 w_entry_ok;
    logic                 w_data_rd;
    logic                 w_last;
    logic                 w_ready;
    logic [A_BITS-1:0]    w_entry_next;
    logic [WIDTH-1:0]     w_sel;
    logic [PAD_W-1:0]     w_pad;
    logic [31:0]          w_word;

    assign w_ctrl_sel   = (debug_addr == 6'h18);
    assign w_data_sel   = (debug_addr == 6'h1C);
    assign w_ctrl_wr    = debug_wr && w_ctrl_sel;
    assign w_start      = w_ctrl_wr && debug_wdata[31];
    assign w_clr        = w_ctrl_wr && debug_wdata[30];
    // The range check looks at the whole index field so an out-of-range entry
    // is caught even though only A_BITS of it are ever stored.
    assign w_entry_ok   = (debug_wdata[29:0] < 30'(DEPTH));
    // A start in the same cycle takes priority over any DATA strobe.
    assign w_data_rd    = debug_rd && w_data_sel && !w_start;
    assign w_last       = (r_word_idx == 8'(WORDS - 1));
    assign w_ready      = (r_state == S_READY);
    assign w_entry_next = (r_entry == A_BITS'(DEPTH - 1)) ? '0 : r_entry + 1'b1;
    assign w_pad        = PAD_W'(r_shadow);

    // Select the addressed entry from the flat latch bus.
    always_comb begin
        w_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_entry == A_BITS'(i)) w_sel = config_bus[i*WIDTH +: WIDTH];
        end
    end

    // Pick the 32-bit shadow word under the read pointer (upper pad bits are 0).
    always_comb begin
        w_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (r_word_idx == 8'(i)) w_word = w_pad[32*i +: 32];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; any start aborts the current sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (w_start && w_entry_ok) w_state_nxt = S_WAIT;
            S_WAIT:    if (!config_busy) w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_READY;
            S_READY: begin
                if (w_data_rd && w_last) begin
`ifdef PRISM_SIT_RB_AUTOINC_EN
                    w_state_nxt = S_WAIT;
`else
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_start) w_state_nxt = w_entry_ok ? S_WAIT : S_IDLE;
    end

    // Entry, pointer, flags and shadow updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_entry    <= '0;
            r_word_idx <= '0;
            r_err      <= 1'b0;
            r_underrun <= 1'b0;
            r_shadow   <= '0;
        end else begin
            if (w_clr) begin
                r_err      <= 1'b0;
                r_underrun <= 1'b0;
            end
            if (w_start) begin
                if (w_entry_ok) r_entry <= debug_wdata[A_BITS-1:0];
                else            r_err   <= 1'b1;
            end else if (w_data_rd) begin
                if (w_ready) begin
                    r_word_idx <= r_word_idx + 8'd1;
`ifdef PRISM_SIT_RB_AUTOINC_EN
                    if (w_last) r_entry <= w_entry_next;
`endif
                end else begin
                    r_underrun <= 1'b1;
                end
            end
            if (r_state == S_CAPTURE && !w_start) begin
                r_shadow   <= w_sel;
                r_word_idx <= '0;
            end
        end
    end

`ifndef PRISM_SIT_RB_AUTOINC_EN
    logic w_unused_next;
    assign w_unused_next = ^w_entry_next;
`endif

    // Debug read mux: zero unless CTRL or DATA is addressed.
    always_comb begin
        debug_rdata = '0;
        if (w_ctrl_sel) begin
            debug_rdata = {w_ready, r_err, r_underrun, 13'b0, r_word_idx, 8'(r_entry)};
        end else if (w_data_sel && w_ready) begin
            debug_rdata = w_word;
        end
    end

endmodule
